// File: rtl/bit_transpose_pkg.sv
// ---------------------------------------------------------------------------
// bit_transpose_pkg
// Shared types and helpers for the bit-matrix transpose scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package bit_transpose_pkg;

  // Scheduler phase: the single buffer is either being filled or drained.
  typedef enum logic [0:0] {
    ST_FILL  = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  localparam int NUM_DEFAULT = 8;
  localparam int W_DEFAULT   = 6;
  localparam int MAX_WIDTH   = 32;

  // Write counter must reach NUM itself (one past the last row).
  function automatic int wcnt_width(input int num);
    return $clog2(num + 1);
  endfunction

  // Read counter only spans output beats 0..W-1.
  function automatic int rcnt_width(input int w);
    return $clog2(w);
  endfunction

  // Reverses the low 'width' bits of v (bit j -> bit width-1-j); upper bits
  // of the result are zero. 'width' is a constant at every call site.
  function automatic logic [MAX_WIDTH-1:0] bitrev(input logic [MAX_WIDTH-1:0] v,
                                                   input int width);
    logic [MAX_WIDTH-1:0] r;
    logic [4:0]           src;
    r = '0;
    for (int j = 0; j < MAX_WIDTH; j++) begin
      if (j < width) begin
        src  = 5'(width - 1 - j);
        r[j] = v[src];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_transpose_sched_if.sv
// ---------------------------------------------------------------------------
// bit_transpose_sched_if
// Input and output stream handshakes of the transpose scheduler.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface bit_transpose_sched_if
  import bit_transpose_pkg::*;
#(
  parameter int NUM = NUM_DEFAULT,
  parameter int W   = W_DEFAULT
);

  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;
  logic [NUM-1:0] out_data;
  logic           out_valid;
  logic           out_last;
  logic           out_ready;

  // Producer/consumer side
  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  // Scheduler side
  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );

endinterface

`default_nettype wire

// File: rtl/bit_transpose_sched.sv
// ---------------------------------------------------------------------------
// bit_transpose_sched
// Buffers NUM words of W bits, then emits W words of NUM bits (transpose).
// Single buffer, fill phase then drain phase, no overlap.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bit_transpose_sched
  import bit_transpose_pkg::*;
#(
  parameter int NUM = NUM_DEFAULT,
  parameter int W   = W_DEFAULT
) (
  input  logic                  clock,
  input  logic                  rst_n,
  input  logic                  cfg_rev,
  bit_transpose_sched_if.slave  bus,
  output logic                  blk_done,
  output logic                  blk_short
);

  localparam int WCW = wcnt_width(NUM);
  localparam int RCW = rcnt_width(W);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(NUM - 1);
  localparam logic [RCW-1:0] RCNT_LAST = RCW'(W - 1);

  state_t               state;
  state_t               state_nxt;
  logic [W-1:0]         rows [NUM];
  logic [WCW-1:0]       wcnt;
  logic [RCW-1:0]       rcnt;
  logic                 rev_lat;

  logic                 in_fire;
  logic                 out_fire;
  logic                 fill_close;
  logic                 drain_close;
  logic                 rev_now;
  logic [MAX_WIDTH-1:0] in_wide;
  logic [MAX_WIDTH-1:0] rev_wide;
  logic [W-1:0]         wr_data;
  logic [NUM-1:0]       col;

  assign in_fire     = bus.in_valid & bus.in_ready;
  assign out_fire    = bus.out_valid & bus.out_ready;
  assign fill_close  = in_fire & ((wcnt == WCNT_LAST) | bus.in_last);
  assign drain_close = out_fire & (rcnt == RCNT_LAST);

  // The first beat of a block uses cfg_rev live; later beats use the latched copy.
  assign rev_now = (wcnt == '0) ? cfg_rev : rev_lat;

  // Widen the input word so the shared reversal helper can operate on it.
  always_comb begin
    in_wide         = '0;
    in_wide[W-1:0]  = bus.in_data;
  end

  assign rev_wide = bitrev(in_wide, W);
  assign wr_data  = rev_now ? rev_wide[W-1:0] : bus.in_data;

  generate
    if (W < MAX_WIDTH) begin : g_rev_tail
      logic rev_tail_unused;
      assign rev_tail_unused = |rev_wide[MAX_WIDTH-1:W];
    end
  endgenerate

  // Output bit k of the current beat is bit rcnt of stored row k.
  generate
    for (genvar k = 0; k < NUM; k++) begin : g_lane
      assign col[k] = rows[k][rcnt];
    end
  endgenerate

  // State register.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: close a fill on the last row or in_last, close a drain on beat W-1.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_FILL:  if (fill_close)  state_nxt = ST_DRAIN;
      ST_DRAIN: if (drain_close) state_nxt = ST_FILL;
      default:  state_nxt = ST_FILL;
    endcase
  end

  // Handshake outputs; in_ready is held low while reset is asserted.
  always_comb begin
    bus.in_ready  = (state == ST_FILL) & rst_n;
    bus.out_valid = (state == ST_DRAIN);
    bus.out_last  = (state == ST_DRAIN) & (rcnt == RCNT_LAST);
    bus.out_data  = (state == ST_DRAIN) ? col : '0;
  end

  // Buffer rows, counters and latched reverse option.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM; k++) rows[k] <= '0;
      wcnt    <= '0;
      rcnt    <= '0;
      rev_lat <= 1'b0;
    end else begin
      if (in_fire) begin
        for (int k = 0; k < NUM; k++) begin
          if (wcnt == WCW'(k)) rows[k] <= wr_data;
        end
        wcnt <= wcnt + WCW'(1);
        if (wcnt == '0) rev_lat <= cfg_rev;
      end
      if (out_fire) begin
        if (rcnt == RCNT_LAST) begin
          // Clear so a following short block sees zero in its unwritten rows.
          for (int k = 0; k < NUM; k++) rows[k] <= '0;
          wcnt <= '0;
          rcnt <= '0;
        end else begin
          rcnt <= rcnt + RCW'(1);
        end
      end
    end
  end

  // Single-cycle status pulses, registered one cycle after the causing beat.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      blk_done  <= 1'b0;
      blk_short <= 1'b0;
    end else begin
      blk_done  <= drain_close;
      blk_short <= in_fire & bus.in_last & (wcnt != WCNT_LAST);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bit_transpose_sched.sv
// ---------------------------------------------------------------------------
// tb_bit_transpose_sched
// Self-checking bench for bit_transpose_sched with a transpose reference model.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bit_transpose_sched;
  import bit_transpose_pkg::*;

  localparam int NUM = 8;
  localparam int W   = 6;

  logic clock   = 1'b0;
  logic rst_n   = 1'b0;
  logic cfg_rev = 1'b0;
  logic blk_done;
  logic blk_short;

  int checks = 0;
  int errors = 0;

  logic [NUM-1:0] exp_beats [W];
  bit             exp_short;

  bit_transpose_sched_if #(.NUM(NUM), .W(W)) bus ();

  bit_transpose_sched #(.NUM(NUM), .W(W)) dut (
    .clock     (clock),
    .rst_n     (rst_n),
    .cfg_rev   (cfg_rev),
    .bus       (bus),
    .blk_done  (blk_done),
    .blk_short (blk_short)
  );

  always #5 clock = ~clock;

  // Reference: reverse a W-bit word arithmetically.
  function automatic int ref_rev(input int v);
    int r = 0;
    for (int j = 0; j < W; j++) if ((v >> j) & 1) r |= (1 << (W - 1 - j));
    return r;
  endfunction

  // Reference: rows beyond n are zero; beat b collects bit b of every row.
  task automatic build_expected(input logic [W-1:0] words [NUM], input int n, input bit rev);
    int rowv [NUM];
    int v;
    for (int k = 0; k < NUM; k++)
      rowv[k] = (k < n) ? (rev ? ref_rev(int'(words[k])) : int'(words[k])) : 0;
    for (int b = 0; b < W; b++) begin
      v = 0;
      for (int k = 0; k < NUM; k++) if ((rowv[k] >> b) & 1) v |= (1 << k);
      exp_beats[b] = v[NUM-1:0];
    end
    exp_short = (n < NUM);
  endtask

  task automatic fill_block(input logic [W-1:0] words [NUM], input int n, input bit rev0,
                            input bit rev_rest, input bit last_full, input string name);
    build_expected(words, n, rev0);
    for (int i = 0; i < n; i++) begin
      bus.in_data  = words[i];
      bus.in_valid = 1'b1;
      bus.in_last  = (i == n - 1) && (n < NUM || last_full);
      cfg_rev      = (i == 0) ? rev0 : rev_rest;
      @(negedge clock);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s fill beat %0d: in_ready=%b out_valid=%b, required 1/0",
                 name, i, bus.in_ready, bus.out_valid);
      end
      @(posedge clock); #1;
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain_block(input int stall_beat, input int stall_len, input int nbeats,
                             input string name);
    int cyc = 0;
    bus.out_ready = 1'b1;
    for (int b = 0; b < nbeats; b++) begin
      if (b == stall_beat) begin
        bus.out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clock);
          checks++;
          if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beats[b] ||
              blk_short !== (cyc == 0 && exp_short)) begin
            errors++;
            $display("FAIL %s stall beat %0d cyc %0d: valid=%b data=%h short=%b, required 1/%h/%b",
                     name, b, s, bus.out_valid, bus.out_data, blk_short, exp_beats[b],
                     (cyc == 0 && exp_short));
          end
          @(posedge clock); #1;
          cyc++;
        end
        bus.out_ready = 1'b1;
      end
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== exp_beats[b] ||
          bus.out_last !== (b == W - 1) || bus.in_ready !== 1'b0 || blk_done !== 1'b0 ||
          blk_short !== (cyc == 0 && exp_short)) begin
        errors++;
        $display("FAIL %s beat %0d: valid=%b data=%h last=%b in_ready=%b done=%b short=%b, required 1/%h/%b/0/0/%b",
                 name, b, bus.out_valid, bus.out_data, bus.out_last, bus.in_ready, blk_done,
                 blk_short, exp_beats[b], (b == W - 1), (cyc == 0 && exp_short));
      end
      @(posedge clock); #1;
      cyc++;
    end
    if (nbeats == W) begin
      @(negedge clock);
      checks++;
      if (blk_done !== 1'b1 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 ||
          bus.out_data !== '0) begin
        errors++;
        $display("FAIL %s close: done=%b in_ready=%b valid=%b data=%h, required 1/1/0/0",
                 name, blk_done, bus.in_ready, bus.out_valid, bus.out_data);
      end
      @(posedge clock); #1;
      @(negedge clock);
      checks++;
      if (blk_done !== 1'b0 || blk_short !== 1'b0) begin
        errors++;
        $display("FAIL %s pulse width: done=%b short=%b, required 0/0", name, blk_done, blk_short);
      end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset();
    bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
        bus.out_data !== '0 || blk_done !== 1'b0 || blk_short !== 1'b0) begin
      errors++;
      $display("FAIL reset values: in_ready=%b valid=%b last=%b data=%h done=%b short=%b, required all 0",
               bus.in_ready, bus.out_valid, bus.out_last, bus.out_data, blk_done, blk_short);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset release: in_ready=%b valid=%b, required 1/0", bus.in_ready, bus.out_valid);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_full();
    logic [W-1:0] w [NUM] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F, 6'h00};
    fill_block(w, NUM, 1'b0, 1'b0, 1'b1, "full");
    drain_block(W, 0, W, "full");
  endtask

  task automatic test_rev();
    logic [W-1:0] w [NUM] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F, 6'h00};
    fill_block(w, NUM, 1'b1, 1'b0, 1'b0, "rev");
    drain_block(W, 0, W, "rev");
  endtask

  task automatic test_short();
    logic [W-1:0] w [NUM] = '{6'h3F, 6'h3F, 6'h3F, 6'h15, 6'h2A, 6'h3F, 6'h3F, 6'h3F};
    fill_block(w, 3, 1'b0, 1'b0, 1'b0, "short");
    drain_block(W, 0, W, "short");
  endtask

  task automatic test_backpressure();
    logic [W-1:0] w [NUM] = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3F, 6'h00};
    fill_block(w, NUM, 1'b0, 1'b0, 1'b1, "bp");
    drain_block(2, 4, W, "bp");
  endtask

  task automatic test_reset_mid_drain();
    logic [W-1:0] w [NUM];
    for (int k = 0; k < NUM; k++) w[k] = W'($urandom_range(0, (1 << W) - 1));
    fill_block(w, NUM, 1'b0, 1'b0, 1'b0, "rst_mid");
    drain_block(W, 0, 3, "rst_mid");
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: valid=%b data=%h in_ready=%b, required 0/0/0",
               bus.out_valid, bus.out_data, bus.in_ready);
    end
    @(posedge clock); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid idle %0d: valid=%b in_ready=%b, required 0/1", c, bus.out_valid, bus.in_ready);
      end
      @(posedge clock); #1;
    end
    for (int k = 0; k < NUM; k++) w[k] = 6'h3F;
    fill_block(w, NUM, 1'b0, 1'b0, 1'b0, "rst_after");
    drain_block(W, 0, W, "rst_after");
  endtask

  task automatic test_random();
    logic [W-1:0] w [NUM];
    int n;
    for (int t = 0; t < 12; t++) begin
      for (int k = 0; k < NUM; k++) w[k] = W'($urandom_range(0, (1 << W) - 1));
      n = $urandom_range(1, NUM);
      fill_block(w, n, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "random");
      drain_block($urandom_range(0, W), $urandom_range(1, 3), W, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] words [2*NUM];
    logic [W-1:0] blk [NUM];
    logic [NUM-1:0] got [$];
    int idx = 0, gap = 0, cycles = 0;
    bit overlap = 0;
    for (int i = 0; i < 2 * NUM; i++) words[i] = W'($urandom_range(0, (1 << W) - 1));
    cfg_rev = 1'b0; bus.in_last = 1'b0; bus.out_ready = 1'b1;
    while ((idx < 2 * NUM || got.size() < 2 * W) && cycles < 200) begin
      bus.in_valid = (idx < 2 * NUM);
      bus.in_data  = words[(idx < 2 * NUM) ? idx : 0];
      @(negedge clock);
      if (bus.in_ready && bus.out_valid) overlap = 1;
      if (idx == NUM && !bus.in_ready) gap++;
      if (bus.in_valid && bus.in_ready) idx++;
      if (bus.out_valid && bus.out_ready) got.push_back(bus.out_data);
      @(posedge clock); #1;
      cycles++;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (cycles >= 200 || got.size() != 2 * W || idx != 2 * NUM) begin
      errors++;
      $display("FAIL b2b progress: cycles=%0d beats=%0d accepted=%0d, required <200/%0d/%0d",
               cycles, got.size(), idx, 2 * W, 2 * NUM);
    end
    checks++;
    if (overlap || gap != W) begin
      errors++;
      $display("FAIL b2b gap: overlap=%0d ready_low=%0d, required 0/%0d", overlap, gap, W);
    end
    for (int bl = 0; bl < 2; bl++) begin
      for (int k = 0; k < NUM; k++) blk[k] = words[bl * NUM + k];
      build_expected(blk, NUM, 1'b0);
      for (int b = 0; b < W; b++) begin
        if (bl * W + b < got.size()) begin
          checks++;
          if (got[bl * W + b] !== exp_beats[b]) begin
            errors++;
            $display("FAIL b2b block %0d beat %0d: got %h required %h", bl, b, got[bl * W + b], exp_beats[b]);
          end
        end
      end
    end
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    test_reset();
    test_full();
    test_rev();
    test_short();
    test_backpressure();
    test_reset_mid_drain();
    test_random();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
